controle_turno: RTL and testbench
=================================

CONTROLE_TURNO -- requirements
Module: controle_turno

Interface
REQ-001 Parameter TOTAL_PECAS, default 17: total ship pieces per player; reaching this many hits wins the game.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles spent waiting for the checker in CHECK.
REQ-003 Parameter TAM_TABULEIRO, default 10: board size; a coordinate is valid when it is less than this value.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 fire  in  1  shot request, single-cycle pulse (already debounced).
REQ-007 x_in, y_in  in  4 each  shot coordinates from player input.
REQ-008 ready  in  1  collision checker finished.
REQ-009 hit  in  1  collision checker hit flag (may be transient).
REQ-010 enable  out  1  start/hold the collision checker.
REQ-011 x, y  out  4 each  latched shot coordinates to the checker.
REQ-012 jogador  out  1  player now firing (0 = P1, 1 = P2).
REQ-013 placar1, placar2  out  5 each  hit counts for P1 and P2.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 fim  out  1  game over.
REQ-016 vencedor  out  1  winning player; valid only while fim=1.

Function
REQ-017 States: IDLE, CHECK, RESULT, FIM; registered FSM.
REQ-018 IDLE: a cycle with fire=1 and x_in, y_in both below TAM_TABULEIRO latches x/y, clears hit_sticky and the timeout counter, and moves to CHECK next edge.
REQ-019 IDLE: fire with any coordinate at or above TAM_TABULEIRO is ignored; state and outputs stay unchanged.
REQ-020 fire is ignored in CHECK, RESULT and FIM; it is not queued.
REQ-021 enable=1 exactly while in CHECK.
REQ-022 x/y stay stable for the whole of CHECK.
REQ-023 CHECK: hit_sticky <= hit_sticky OR hit on every edge.
REQ-024 CHECK: the timeout counter increments on every edge.
REQ-025 CHECK -> RESULT on the first edge with ready=1, or when the counter equals TIMEOUT-1; a timeout is treated as a miss unless hit_sticky is already set.
REQ-026 If ready and hit are both high on the same edge, that hit is included in the result.
REQ-027 RESULT lasts exactly one cycle with enable=0; this guarantees the checker sees enable low between shots.
REQ-028 RESULT on a hit: the score of the current player increments by 1, saturating at TOTAL_PECAS, and jogador is unchanged (a hit earns another shot).
REQ-029 RESULT on a miss: jogador toggles and no score changes.
REQ-030 RESULT: if the new score equals TOTAL_PECAS, go to FIM with vencedor = jogador; otherwise go to IDLE.
REQ-031 FIM is absorbing: fim=1, enable=0, and every output holds until reset.
REQ-032 Latency from an accepted fire to IDLE is (cycles in CHECK) + 2.
REQ-033 Scores never exceed TOTAL_PECAS and never wrap.

Reset
REQ-034 While reset=1, regardless of state: state=IDLE, enable=0, x=y=0, jogador=0, placar1=placar2=0, busy=0, fim=0, vencedor=0, hit_sticky=0, timeout counter=0.
REQ-035 Reset during CHECK drops enable asynchronously in the same cycle; no score update occurs.
REQ-036 The first fire can be accepted on the first clk edge after reset falls.

Structure
REQ-037 A shared package holds the state encoding, the TOTAL_PECAS and TAM_TABULEIRO defaults, and the score width (5).
REQ-038 One sub-module, placar_jogador, is instantiated twice: a saturating 5-bit counter with inc and limit inputs and async reset.
REQ-039 The FSM, timeout counter, and hit_sticky live in controle_turno.

Verification
REQ-040 Miss: fire (3,4), hit=0, ready in the 12th CHECK cycle -> enable high 12 cycles, RESULT, jogador 0->1, scores 0/0.
REQ-041 Transient hit: hit pulses 1 cycle mid-CHECK, then ready -> placar1=1, jogador stays 0.
REQ-042 Timeout: ready never asserted, TIMEOUT=15 -> RESULT after 15 CHECK cycles, treated as a miss, jogador toggles.
REQ-043 Invalid input and busy: fire (10,2) in IDLE ignored; fire during CHECK ignored; busy and x/y unchanged.
REQ-044 Win: P2 scores 17 consecutive hits -> placar2=17, fim=1, vencedor=1; a later fire gives no response.
REQ-045 Reset mid-CHECK: reset asserted -> enable=0 immediately, all outputs cleared; the next valid fire is accepted normally.

Source files
------------

// File: rtl/controle_turno_pkg.sv
// Shared definitions for the turn controller.
//   estado_t           : FSM state encoding (IDLE, CHECK, RESULT, FIM)
//   TOTAL_PECAS_PADRAO : default number of ship pieces per player
//   TAM_TABULEIRO_PADRAO : default board size (valid coordinate < size)
//   LARG_PLACAR        : score counter width
package controle_turno_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      RESULT = 2'd2,
      FIM    = 2'd3
   } estado_t;

   localparam int TOTAL_PECAS_PADRAO   = 17;
   localparam int TAM_TABULEIRO_PADRAO = 10;
   localparam int LARG_PLACAR          = 5;

endpackage

// File: rtl/placar_jogador.sv
// Saturating score counter for one player.
//   clk, reset : clock and asynchronous active-high reset
//   inc        : add one to the score this edge
//   limit      : ceiling; the score never goes past it
//   valor      : current score
module placar_jogador
   import controle_turno_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inc,
   input  logic [LARG_PLACAR-1:0] limit,
   output logic [LARG_PLACAR-1:0] valor
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valor <= '0;
      end else if (inc && (valor < limit)) begin
         valor <= valor + LARG_PLACAR'(1);
      end
   end

endmodule

// File: rtl/controle_turno.sv
// Battleship turn controller.
//   clk, reset        : clock and asynchronous active-high reset
//   fire, x_in, y_in  : shot request pulse and coordinates
//   ready, hit        : collision checker done / hit flag (hit may be transient)
//   enable, x, y      : checker start/hold and latched coordinates
//   jogador           : player firing now (0 = P1, 1 = P2)
//   placar1, placar2  : scores
//   busy, fim         : not-IDLE / game over
//   vencedor          : winning player, valid while fim = 1
module controle_turno
   import controle_turno_pkg::*;
#(
   parameter int TOTAL_PECAS   = TOTAL_PECAS_PADRAO,
   parameter int TIMEOUT       = 15,
   parameter int TAM_TABULEIRO = TAM_TABULEIRO_PADRAO
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fire,
   input  logic [3:0]             x_in,
   input  logic [3:0]             y_in,
   input  logic                   ready,
   input  logic                   hit,
   output logic                   enable,
   output logic [3:0]             x,
   output logic [3:0]             y,
   output logic                   jogador,
   output logic [LARG_PLACAR-1:0] placar1,
   output logic [LARG_PLACAR-1:0] placar2,
   output logic                   busy,
   output logic                   fim,
   output logic                   vencedor
);

   localparam logic [LARG_PLACAR-1:0] LIMITE    = LARG_PLACAR'(TOTAL_PECAS);
   localparam logic [7:0]             CONT_FIM  = 8'(TIMEOUT - 1);

   estado_t                estado;
   logic                   hit_sticky;
   logic [7:0]             cont;
   logic                   coord_ok;
   logic                   inc1;
   logic                   inc2;
   logic [LARG_PLACAR-1:0] placar_atual;
   logic [LARG_PLACAR-1:0] placar_novo;

   assign coord_ok = ({28'd0, x_in} < 32'(TAM_TABULEIRO)) &&
                     ({28'd0, y_in} < 32'(TAM_TABULEIRO));

   // Outputs decoded straight from the state register, so they change only
   // on clock edges and drop together with the async reset.
   assign enable = (estado == CHECK);
   assign busy   = (estado != IDLE);
   assign fim    = (estado == FIM);

   assign inc1 = (estado == RESULT) && hit_sticky && !jogador;
   assign inc2 = (estado == RESULT) && hit_sticky &&  jogador;

   // Score the current player will hold after this RESULT edge; used to
   // decide the move to FIM in the same cycle the counter updates.
   assign placar_atual = jogador ? placar2 : placar1;
   assign placar_novo  = (placar_atual < LIMITE) ? placar_atual + LARG_PLACAR'(1)
                                                 : placar_atual;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado     <= IDLE;
         x          <= '0;
         y          <= '0;
         jogador    <= 1'b0;
         vencedor   <= 1'b0;
         hit_sticky <= 1'b0;
         cont       <= '0;
      end else begin
         case (estado)
            IDLE: begin
               if (fire && coord_ok) begin
                  x          <= x_in;
                  y          <= y_in;
                  hit_sticky <= 1'b0;
                  cont       <= '0;
                  estado     <= CHECK;
               end
            end
            CHECK: begin
               // A hit seen on the same edge as ready still counts.
               hit_sticky <= hit_sticky | hit;
               cont       <= cont + 8'd1;
               if (ready || (cont == CONT_FIM)) begin
                  estado <= RESULT;
               end
            end
            RESULT: begin
               if (hit_sticky) begin
                  if (placar_novo == LIMITE) begin
                     vencedor <= jogador;
                     estado   <= FIM;
                  end else begin
                     estado <= IDLE;
                  end
               end else begin
                  jogador <= ~jogador;
                  estado  <= IDLE;
               end
            end
            FIM: begin
               estado <= FIM;
            end
            default: begin
               estado <= IDLE;
            end
         endcase
      end
   end

   placar_jogador u_placar1 (
      .clk   (clk),
      .reset (reset),
      .inc   (inc1),
      .limit (LIMITE),
      .valor (placar1)
   );

   placar_jogador u_placar2 (
      .clk   (clk),
      .reset (reset),
      .inc   (inc2),
      .limit (LIMITE),
      .valor (placar2)
   );

endmodule

// File: tb/tb_controle_turno.sv
// Self-checking bench for controle_turno: directed vector table, hand-written
// corner sequences, and random shots against a shot-level reference model.
module tb_controle_turno;

   localparam int TOTAL = 17;
   localparam int TMO   = 15;

   logic       clk;
   logic       reset;
   logic       fire;
   logic [3:0] x_in;
   logic [3:0] y_in;
   logic       ready;
   logic       hit;
   logic       enable;
   logic [3:0] x;
   logic [3:0] y;
   logic       jogador;
   logic [4:0] placar1;
   logic [4:0] placar2;
   logic       busy;
   logic       fim;
   logic       vencedor;

   controle_turno #(
      .TOTAL_PECAS   (TOTAL),
      .TIMEOUT       (TMO),
      .TAM_TABULEIRO (10)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .fire     (fire),
      .x_in     (x_in),
      .y_in     (y_in),
      .ready    (ready),
      .hit      (hit),
      .enable   (enable),
      .x        (x),
      .y        (y),
      .jogador  (jogador),
      .placar1  (placar1),
      .placar2  (placar2),
      .busy     (busy),
      .fim      (fim),
      .vencedor (vencedor)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: game state at shot granularity.
   int m_sc[2];
   int m_jog;
   int m_fim;
   int m_venc;

   typedef struct {
      int xi;
      int yi;
      int ra;     // CHECK cycle with ready=1 (0 = never)
      int ha;     // CHECK cycle with a one-cycle hit pulse (0 = none)
      int fm;     // CHECK cycle with a stray fire (0 = none)
      int e_cyc;
      int e_jog;
      int e_p1;
      int e_p2;
   } vec_t;

   vec_t tab[7];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sc[0] = 0;
      m_sc[1] = 0;
      m_jog   = 0;
      m_fim   = 0;
      m_venc  = 0;
   endtask

   // Applies one shot outcome to the model; returns expected CHECK length.
   task automatic model_shot(input int ra, input int ha, output int cyc);
      int h;
      cyc = (ra >= 1 && ra <= TMO) ? ra : TMO;
      h   = (ha >= 1 && ha <= cyc) ? 1 : 0;
      if (h == 1) begin
         if (m_sc[m_jog] < TOTAL) m_sc[m_jog] = m_sc[m_jog] + 1;
         if (m_sc[m_jog] == TOTAL) begin
            m_fim  = 1;
            m_venc = m_jog;
         end
      end else begin
         m_jog = 1 - m_jog;
      end
   endtask

   // Entered #1 after a posedge with the DUT in IDLE; leaves #1 after the
   // edge that ends RESULT.
   task automatic do_shot(input int xi, input int yi, input int ra,
                          input int ha, input int fm, output int ncyc);
      fire  = 1'b1;
      x_in  = 4'(xi);
      y_in  = 4'(yi);
      ready = 1'b0;
      hit   = 1'b0;
      @(posedge clk); #1;
      fire = 1'b0;
      ncyc = 0;
      for (int k = 1; k <= 40; k++) begin
         if (!enable) break;
         chk("xy_hold", int'({x, y}), (xi << 4) | yi);
         chk("busy_check", int'(busy), 1);
         hit   = (k == ha);
         ready = (k == ra);
         fire  = (k == fm);
         x_in  = 4'd1;
         y_in  = 4'd2;
         @(posedge clk); #1;
         ncyc  = k;
         hit   = 1'b0;
         ready = 1'b0;
         fire  = 1'b0;
      end
      chk("result_enable", int'(enable), 0);
      chk("result_busy", int'(busy), 1);
      @(posedge clk); #1;
   endtask

   task automatic check_state(input string tag, input int ecyc, input int acyc);
      chk({tag, "_cycles"}, acyc, ecyc);
      chk({tag, "_jogador"}, int'(jogador), m_jog);
      chk({tag, "_placar1"}, int'(placar1), m_sc[0]);
      chk({tag, "_placar2"}, int'(placar2), m_sc[1]);
      chk({tag, "_fim"}, int'(fim), m_fim);
      chk({tag, "_busy"}, int'(busy), m_fim);
      chk({tag, "_enable"}, int'(enable), 0);
      if (m_fim == 1) chk({tag, "_vencedor"}, int'(vencedor), m_venc);
   endtask

   task automatic do_invalid(input int xi, input int yi);
      int xo;
      int yo;
      int jo;
      xo   = int'(x);
      yo   = int'(y);
      jo   = int'(jogador);
      fire = 1'b1;
      x_in = 4'(xi);
      y_in = 4'(yi);
      @(posedge clk); #1;
      fire = 1'b0;
      chk("inv_busy", int'(busy), 0);
      chk("inv_enable", int'(enable), 0);
      chk("inv_x", int'(x), xo);
      chk("inv_y", int'(y), yo);
      chk("inv_jogador", int'(jogador), jo);
      @(posedge clk); #1;
      chk("inv_busy2", int'(busy), 0);
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_enable"}, int'(enable), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_xy"}, int'({x, y}), 0);
      chk({tag, "_jogador"}, int'(jogador), 0);
      chk({tag, "_placares"}, int'({placar1, placar2}), 0);
      chk({tag, "_fim"}, int'(fim), 0);
      chk({tag, "_vencedor"}, int'(vencedor), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      check_cleared("rst");
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int ecyc;
      int xi;
      int yi;
      int ra;
      int ha;
      int fm;

      tab[0] = '{3, 4, 12, 0, 0, 12, 1, 0, 0};   // plain miss
      tab[1] = '{5, 5, 8, 3, 0, 8, 1, 0, 1};     // transient hit, P2 keeps turn
      tab[2] = '{9, 9, 0, 0, 0, 15, 0, 0, 1};    // timeout = miss
      tab[3] = '{0, 0, 5, 5, 0, 5, 0, 1, 1};     // hit with ready same cycle
      tab[4] = '{2, 7, 6, 0, 2, 6, 1, 1, 1};     // stray fire during CHECK
      tab[5] = '{1, 1, 0, 15, 0, 15, 1, 1, 2};   // hit on the timeout edge
      tab[6] = '{4, 4, 3, 4, 0, 3, 0, 1, 2};     // hit after ready not counted

      reset = 1'b1;
      fire  = 1'b0;
      x_in  = '0;
      y_in  = '0;
      ready = 1'b0;
      hit   = 1'b0;
      model_reset();
      #2;
      check_cleared("por");
      @(posedge clk); #1;
      reset = 1'b0;

      for (int i = 0; i < 7; i++) begin
         do_shot(tab[i].xi, tab[i].yi, tab[i].ra, tab[i].ha, tab[i].fm, cyc);
         model_shot(tab[i].ra, tab[i].ha, ecyc);
         chk($sformatf("vec%0d_cycles", i), cyc, tab[i].e_cyc);
         chk($sformatf("vec%0d_jogador", i), int'(jogador), tab[i].e_jog);
         chk($sformatf("vec%0d_placar1", i), int'(placar1), tab[i].e_p1);
         chk($sformatf("vec%0d_placar2", i), int'(placar2), tab[i].e_p2);
         chk($sformatf("vec%0d_busy", i), int'(busy), 0);
         if (i == 0) begin
            do_invalid(10, 2);
            do_invalid(2, 15);
         end
      end

      // Reset in the middle of CHECK, then a normal shot.
      fire = 1'b1;
      x_in = 4'd6;
      y_in = 4'd6;
      @(posedge clk); #1;
      fire = 1'b0;
      hit  = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("midchk_enable_before", int'(enable), 1);
      reset = 1'b1;
      #1;
      check_cleared("midchk");
      @(posedge clk); #1;
      hit   = 1'b0;
      reset = 1'b0;
      model_reset();
      do_shot(7, 8, 4, 0, 0, cyc);
      model_shot(4, 0, ecyc);
      check_state("after_rst", ecyc, cyc);

      // P2 wins with 17 consecutive hits.
      do_reset();
      do_shot(3, 3, 2, 0, 0, cyc);
      model_shot(2, 0, ecyc);
      check_state("win_miss", ecyc, cyc);
      for (int i = 0; i < TOTAL; i++) begin
         do_shot(1, 2, 2, 1, 0, cyc);
         model_shot(2, 1, ecyc);
         check_state($sformatf("win%0d", i), ecyc, cyc);
      end
      chk("win_placar2", int'(placar2), 17);
      chk("win_fim", int'(fim), 1);
      chk("win_vencedor", int'(vencedor), 1);
      fire = 1'b1;
      x_in = 4'd5;
      y_in = 4'd5;
      @(posedge clk); #1;
      fire = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("fim_enable", int'(enable), 0);
         chk("fim_hold", int'({fim, vencedor, placar2, x, y}), (1 << 14) | (1 << 13) | (17 << 8) | (1 << 4) | 2);
         @(posedge clk); #1;
      end

      // Random shots against the model.
      do_reset();
      for (int i = 0; i < 60; i++) begin
         if (m_fim == 1) do_reset();
         xi = $urandom_range(0, 15);
         yi = $urandom_range(0, 15);
         if (xi >= 10 || yi >= 10) begin
            do_invalid(xi, yi);
         end else begin
            ra = $urandom_range(0, 18);
            ha = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 8);
            fm = $urandom_range(0, 3);
            do_shot(xi, yi, ra, ha, fm, cyc);
            model_shot(ra, ha, ecyc);
            check_state("rnd", ecyc, cyc);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
